// File: rtl/vga_native_regfile.sv
// VGA controller native-side register file.
// Holds shadow copies of CTRL/FB_BASE/BG_COLOR that move to the active
// outputs at frame boundaries, plus sticky STATUS, FRAME_CNT, ID and IRQ_EN.
module vga_native_regfile #(
  parameter int          NATIVE_ADDR_WIDTH = 4,
  parameter logic [31:0] ID_VALUE          = 32'h5647_4131
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         write_en,
  input  logic [NATIVE_ADDR_WIDTH-1:0] addr_write,
  input  logic [31:0]                  data2native,
  input  logic                         read_en_sync,
  input  logic [NATIVE_ADDR_WIDTH-1:0] addr_read,
  output logic [31:0]                  data2axil,
  input  logic                         frame_start,
  input  logic                         underflow,
  output logic [3:0]                   ctrl_active,
  output logic [31:0]                  fb_base_active,
  output logic [11:0]                  bg_color_active,
  output logic                         irq
);

  localparam logic [NATIVE_ADDR_WIDTH-1:0] A_CTRL   = NATIVE_ADDR_WIDTH'(0);
  localparam logic [NATIVE_ADDR_WIDTH-1:0] A_FBBASE = NATIVE_ADDR_WIDTH'(1);
  localparam logic [NATIVE_ADDR_WIDTH-1:0] A_BGCOL  = NATIVE_ADDR_WIDTH'(2);
  localparam logic [NATIVE_ADDR_WIDTH-1:0] A_STATUS = NATIVE_ADDR_WIDTH'(3);
  localparam logic [NATIVE_ADDR_WIDTH-1:0] A_FCNT   = NATIVE_ADDR_WIDTH'(4);
  localparam logic [NATIVE_ADDR_WIDTH-1:0] A_ID     = NATIVE_ADDR_WIDTH'(5);
  localparam logic [NATIVE_ADDR_WIDTH-1:0] A_IRQEN  = NATIVE_ADDR_WIDTH'(6);

  logic [3:0]  r_ctrl_sh, r_ctrl_act;
  logic [31:0] r_fb_sh, r_fb_act;
  logic [11:0] r_bg_sh, r_bg_act;
  logic [1:0]  r_status, r_irq_en;
  logic [31:0] r_frame_cnt, r_rdata;
  logic        r_irq;

  logic        w_wr_ctrl, w_wr_fb, w_wr_bg, w_wr_status, w_wr_irqen;
  logic        w_load_act;
  logic [1:0]  w_status_set, w_status_clr;
  logic [31:0] w_rdata;

  assign w_wr_ctrl   = write_en && (addr_write == A_CTRL);
  assign w_wr_fb     = write_en && (addr_write == A_FBBASE);
  assign w_wr_bg     = write_en && (addr_write == A_BGCOL);
  assign w_wr_status = write_en && (addr_write == A_STATUS);
  assign w_wr_irqen  = write_en && (addr_write == A_IRQEN);

  // Active copies track shadows at frame start, or continuously while disabled.
  assign w_load_act   = frame_start || !r_ctrl_act[0];
  assign w_status_set = {underflow, frame_start};
  assign w_status_clr = w_wr_status ? data2native[1:0] : 2'b00;

  // Shadow and plain RW registers take native writes.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_ctrl_sh <= '0;
      r_fb_sh   <= '0;
      r_bg_sh   <= '0;
      r_irq_en  <= '0;
    end else begin
      if (w_wr_ctrl)  r_ctrl_sh <= data2native[3:0];
      if (w_wr_fb)    r_fb_sh   <= data2native;
      if (w_wr_bg)    r_bg_sh   <= data2native[11:0];
      if (w_wr_irqen) r_irq_en  <= data2native[1:0];
    end
  end

  // Active outputs sample the pre-edge shadow, so a coincident write waits a frame.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_ctrl_act <= '0;
      r_fb_act   <= '0;
      r_bg_act   <= '0;
    end else if (w_load_act) begin
      r_ctrl_act <= r_ctrl_sh;
      r_fb_act   <= r_fb_sh;
      r_bg_act   <= r_bg_sh;
    end
  end

  // Sticky status with W1C; a hardware set wins over a same-cycle clear.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_status    <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_status <= (r_status & ~w_status_clr) | w_status_set;
      if (frame_start) r_frame_cnt <= r_frame_cnt + 32'd1;
    end
  end

  // Registered interrupt level from pre-edge status and enables.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_irq <= 1'b0;
    else         r_irq <= |(r_status & r_irq_en);
  end

  // Read mux over pre-edge register values; unmapped reads return zero.
  always_comb begin
    w_rdata = '0;
    case (addr_read)
      A_CTRL:   w_rdata = {28'd0, r_ctrl_sh};
      A_FBBASE: w_rdata = r_fb_sh;
      A_BGCOL:  w_rdata = {20'd0, r_bg_sh};
      A_STATUS: w_rdata = {30'd0, r_status};
      A_FCNT:   w_rdata = r_frame_cnt;
      A_ID:     w_rdata = ID_VALUE;
      A_IRQEN:  w_rdata = {30'd0, r_irq_en};
      default:  w_rdata = '0;
    endcase
  end

  // Read data register holds until the next read strobe.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)           r_rdata <= '0;
    else if (read_en_sync) r_rdata <= w_rdata;
  end

  assign data2axil       = r_rdata;
  assign ctrl_active     = r_ctrl_act;
  assign fb_base_active  = r_fb_act;
  assign bg_color_active = r_bg_act;
  assign irq             = r_irq;

endmodule
